sad_best_mv: RTL and testbench

SAD_BEST_MV -- requirements
Module: sad_best_mv

---
 rtl/me_pkg.sv | 29 ++
 rtl/mv_out_buf.sv | 79 +++++++
 rtl/sad_best_mv.sv | 164 ++++++++++++++++
 tb/tb_sad_best_mv.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared defaults and state encoding for the SAD best-vector tracker
//
// Purpose: holds the default widths and frame geometry used by sad_best_mv
// and mv_out_buf, plus the tracker FSM state enum.
// Ports: none (package).
package me_pkg;

  // Default candidate vector and SAD widths.
  localparam int MV_W_DFLT         = 4;
  localparam int SAD_W_DFLT        = 16;

  // Default frame geometry in 4x4-pixel blocks (1920x1080 frame).
  localparam int BLKS_PER_ROW_DFLT = 480;
  localparam int BLK_ROWS_DFLT     = 270;

  // Block position index width (covers 0..479 and 0..269).
  localparam int POS_W             = 9;

  // Candidate counter: 5 bits, saturating, 16 candidates per full block.
  localparam int             CNT_W       = 5;
  localparam logic [CNT_W-1:0] CNT_MAX     = 5'd31;
  localparam logic [CNT_W-1:0] CAND_TARGET = 5'd16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_t;

endpackage

// File: rtl/mv_out_buf.sv
// rtl/mv_out_buf.sv - single-entry result register with ready/valid handshake
//
// Purpose: captures a closed block's winning vector, SAD and position, holds
// it until the consumer accepts it, and flags results lost to a full register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load                 a block closed this cycle; load_* carry its result
//   load_mv/sad/x/y      result of the closing block
//   out_ready            consumer accepts the held result
//   out_valid            result register is occupied
//   best_mv/best_sad     held winning vector and SAD
//   blk_x/blk_y          held block position
//   frame_done           handshake of the last block of a frame (combinational)
//   err_ovf              sticky: a result was dropped because the register was full
module mv_out_buf
  import me_pkg::*;
#(
  parameter int MV_W         = MV_W_DFLT,
  parameter int SAD_W        = SAD_W_DFLT,
  parameter int BLKS_PER_ROW = BLKS_PER_ROW_DFLT,
  parameter int BLK_ROWS     = BLK_ROWS_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [MV_W-1:0]  load_mv,
  input  logic [SAD_W-1:0] load_sad,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [MV_W-1:0]  best_mv,
  output logic [SAD_W-1:0] best_sad,
  output logic [POS_W-1:0] blk_x,
  output logic [POS_W-1:0] blk_y,
  output logic             frame_done,
  output logic             err_ovf
);

  localparam logic [POS_W-1:0] X_LAST = POS_W'(BLKS_PER_ROW - 1);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(BLK_ROWS - 1);

  logic handshake;
  logic can_load;

  assign handshake = out_valid && out_ready;
  // The register can take a new result if it is empty or is being drained
  // this very cycle.
  assign can_load  = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      best_mv   <= '0;
      best_sad  <= '0;
      blk_x     <= '0;
      blk_y     <= '0;
      err_ovf   <= 1'b0;
    end else begin
      if (load) begin
        if (can_load) begin
          out_valid <= 1'b1;
          best_mv   <= load_mv;
          best_sad  <= load_sad;
          blk_x     <= load_x;
          blk_y     <= load_y;
        end else begin
          // Old result stays put; the new one is lost.
          err_ovf <= 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign frame_done = handshake && (blk_x == X_LAST) && (blk_y == Y_LAST);

endmodule

// File: rtl/sad_best_mv.sv
// rtl/sad_best_mv.sv - per-block minimum-SAD motion vector selector
//
// Purpose: watches a stream of (vector, SAD) candidates per 4x4 block, keeps
// the smallest SAD (earliest wins ties), and on block close hands the winner
// and its raster position to the output register.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   compare              candidate strobe; a low cycle after a run closes the block
//   mv_vertical, sad_in  candidate vector and its SAD
//   out_ready            consumer accepts the reported result
//   out_valid            result available
//   best_mv, best_sad    winning vector and SAD of the reported block
//   blk_x, blk_y         column/row of the reported block
//   frame_done           pulse on handshake of the frame's last block
//   err_short            sticky: a block closed without exactly 16 candidates
//   err_ovf              sticky: a result was dropped because the output was full
module sad_best_mv
  import me_pkg::*;
#(
  parameter int MV_W         = MV_W_DFLT,
  parameter int SAD_W        = SAD_W_DFLT,
  parameter int BLKS_PER_ROW = BLKS_PER_ROW_DFLT,
  parameter int BLK_ROWS     = BLK_ROWS_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             compare,
  input  logic [MV_W-1:0]  mv_vertical,
  input  logic [SAD_W-1:0] sad_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [MV_W-1:0]  best_mv,
  output logic [SAD_W-1:0] best_sad,
  output logic [8:0]       blk_x,
  output logic [8:0]       blk_y,
  output logic             frame_done,
  output logic             err_short,
  output logic             err_ovf
);

  localparam logic [POS_W-1:0] X_LAST = POS_W'(BLKS_PER_ROW - 1);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(BLK_ROWS - 1);

  trk_state_t state;
  trk_state_t state_nxt;

  logic [MV_W-1:0]  run_mv;
  logic [SAD_W-1:0] run_sad;
  logic [CNT_W-1:0] cand_cnt;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic             close;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    close     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (compare) begin
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (!compare) begin
          state_nxt = ST_IDLE;
          close     = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ running minimum
  // The first candidate of a block seeds the minimum unconditionally; later
  // ones replace it only when strictly smaller, so ties keep the earlier
  // vector. The running values are frozen while compare is low, which is
  // exactly when the close hands them to the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_mv   <= '0;
      run_sad  <= '0;
      cand_cnt <= '0;
    end else if (compare) begin
      if (state == ST_IDLE) begin
        run_mv   <= mv_vertical;
        run_sad  <= sad_in;
        cand_cnt <= CNT_W'(1);
      end else begin
        if (sad_in < run_sad) begin
          run_mv  <= mv_vertical;
          run_sad <= sad_in;
        end
        if (cand_cnt != CNT_MAX) begin
          cand_cnt <= cand_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_short <= 1'b0;
    end else if (close && (cand_cnt != CAND_TARGET)) begin
      err_short <= 1'b1;
    end
  end

  // ------------------------------------------------------ block position
  // Advances on every close, including results the output register drops,
  // so reported positions always match the raster order of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (close) begin
      if (pos_x == X_LAST) begin
        pos_x <= '0;
        if (pos_y == Y_LAST) begin
          pos_y <= '0;
        end else begin
          pos_y <= pos_y + POS_W'(1);
        end
      end else begin
        pos_x <= pos_x + POS_W'(1);
      end
    end
  end

  // ------------------------------------------------------ output register
  mv_out_buf #(
    .MV_W         (MV_W),
    .SAD_W        (SAD_W),
    .BLKS_PER_ROW (BLKS_PER_ROW),
    .BLK_ROWS     (BLK_ROWS)
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (close),
    .load_mv    (run_mv),
    .load_sad   (run_sad),
    .load_x     (pos_x),
    .load_y     (pos_y),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .best_mv    (best_mv),
    .best_sad   (best_sad),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .frame_done (frame_done),
    .err_ovf    (err_ovf)
  );

endmodule

// File: tb/tb_sad_best_mv.sv
// tb/tb_sad_best_mv.sv - directed self-checking bench for sad_best_mv
module tb_sad_best_mv;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main instance: default 1920x1080 geometry.
  logic        compare;
  logic [3:0]  mv_vertical;
  logic [15:0] sad_in;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  best_mv;
  logic [15:0] best_sad;
  logic [8:0]  blk_x;
  logic [8:0]  blk_y;
  logic        frame_done;
  logic        err_short;
  logic        err_ovf;

  // Small-frame instance (3x2 blocks) so a whole frame fits in a short run.
  logic        f_compare;
  logic [3:0]  f_mv;
  logic [15:0] f_sad;
  logic        f_ready;
  logic        f_valid;
  logic [3:0]  f_best_mv;
  logic [15:0] f_best_sad;
  logic [8:0]  f_blk_x;
  logic [8:0]  f_blk_y;
  logic        f_frame_done;
  logic        f_err_short;
  logic        f_err_ovf;

  sad_best_mv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .compare     (compare),
    .mv_vertical (mv_vertical),
    .sad_in      (sad_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .best_mv     (best_mv),
    .best_sad    (best_sad),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .frame_done  (frame_done),
    .err_short   (err_short),
    .err_ovf     (err_ovf)
  );

  sad_best_mv #(
    .BLKS_PER_ROW (3),
    .BLK_ROWS     (2)
  ) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .compare     (f_compare),
    .mv_vertical (f_mv),
    .sad_in      (f_sad),
    .out_ready   (f_ready),
    .out_valid   (f_valid),
    .best_mv     (f_best_mv),
    .best_sad    (f_best_sad),
    .blk_x       (f_blk_x),
    .blk_y       (f_blk_y),
    .frame_done  (f_frame_done),
    .err_short   (f_err_short),
    .err_ovf     (f_err_ovf)
  );

  int checks = 0;
  int errors = 0;
  int fd_main = 0;
  int fd_small = 0;

  logic [15:0] tbl [16];

  always @(negedge clk) begin
    if (frame_done)   fd_main  = fd_main + 1;
    if (f_frame_done) fd_small = fd_small + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n candidates (mv = index) then one compare=0 cycle; out_ready takes
  // rdy on the closing cycle. Returns just after the edge that loads the result.
  task automatic send_block(input logic [15:0] sads [16], input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      compare     = 1'b1;
      mv_vertical = 4'(i);
      sad_in      = sads[i];
      tick();
    end
    compare     = 1'b0;
    mv_vertical = 4'd0;
    sad_in      = 16'd0;
    out_ready   = rdy;
    tick();
  endtask

  task automatic fill_tbl(input int win, input logic [15:0] win_sad, input logic [15:0] other);
    for (int i = 0; i < 16; i++) tbl[i] = (i == win) ? win_sad : other;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    compare = 1'b0;
    f_compare = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    compare = 1'b0; mv_vertical = 4'd0; sad_in = 16'd0; out_ready = 1'b1;
    f_compare = 1'b0; f_mv = 4'd0; f_sad = 16'd0; f_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (best_mv !== 4'd0) begin errors++; $display("FAIL reset_best_mv got %0d want 0", best_mv); end
    checks++; if (best_sad !== 16'd0) begin errors++; $display("FAIL reset_best_sad got %0d want 0", best_sad); end
    checks++; if ({blk_x, blk_y} !== 18'd0) begin errors++; $display("FAIL reset_blk got (%0d,%0d) want (0,0)", blk_x, blk_y); end
    checks++; if ({frame_done, err_short, err_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_done, err_short, err_ovf}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    tbl = '{16'd50, 16'd40, 16'd45, 16'd60, 16'd35, 16'd30, 16'd30, 16'd70,
            16'd31, 16'd99, 16'd40, 16'd33, 16'd266, 16'd30, 16'd65535, 16'd80};
    send_block(tbl, 16, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
    checks++; if (best_mv !== 4'd5) begin errors++; $display("FAIL basic_mv got %0d want 5", best_mv); end
    checks++; if (best_sad !== 16'd30) begin errors++; $display("FAIL basic_sad got %0d want 30", best_sad); end
    checks++; if ({blk_x, blk_y} !== 18'd0) begin errors++; $display("FAIL basic_blk got (%0d,%0d) want (0,0)", blk_x, blk_y); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL basic_err_short got %0b want 0", err_short); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_ties();
    fill_tbl(3, 16'd7, 16'd100);
    tbl[9] = 16'd7;
    send_block(tbl, 16, 1'b1);
    checks++; if (best_mv !== 4'd3) begin errors++; $display("FAIL ties_mv got %0d want 3", best_mv); end
    checks++; if (best_sad !== 16'd7) begin errors++; $display("FAIL ties_sad got %0d want 7", best_sad); end
    checks++; if (blk_x !== 9'd1) begin errors++; $display("FAIL ties_blk_x got %0d want 1", blk_x); end
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    fill_tbl(2, 16'd10, 16'd20);
    send_block(tbl, 16, 1'b0);
    checks++; if (out_valid !== 1'b1 || best_mv !== 4'd2) begin errors++; $display("FAIL ovf_first got valid=%0b mv=%0d want valid=1 mv=2", out_valid, best_mv); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", err_ovf); end
    fill_tbl(7, 16'd1, 16'd50);
    send_block(tbl, 16, 1'b0);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", err_ovf); end
    checks++; if (best_mv !== 4'd2 || best_sad !== 16'd10 || blk_x !== 9'd2) begin errors++; $display("FAIL ovf_held got mv=%0d sad=%0d x=%0d want mv=2 sad=10 x=2", best_mv, best_sad, blk_x); end
    fill_tbl(11, 16'd4, 16'd90);
    send_block(tbl, 16, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_third_valid got %0b want 1", out_valid); end
    checks++; if (best_mv !== 4'd11 || best_sad !== 16'd4) begin errors++; $display("FAIL ovf_third got mv=%0d sad=%0d want mv=11 sad=4", best_mv, best_sad); end
    checks++; if (blk_x !== 9'd4 || blk_y !== 9'd0) begin errors++; $display("FAIL ovf_third_blk got (%0d,%0d) want (4,0)", blk_x, blk_y); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain got %0b want 0", out_valid); end
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL ovf_err_short got %0b want 0", err_short); end
  endtask

  task automatic test_short();
    fill_tbl(4, 16'd2, 16'd9);
    send_block(tbl, 10, 1'b1);
    checks++; if (out_valid !== 1'b1 || best_mv !== 4'd4 || best_sad !== 16'd2) begin errors++; $display("FAIL short_result got valid=%0b mv=%0d sad=%0d want 1/4/2", out_valid, best_mv, best_sad); end
    checks++; if (blk_x !== 9'd5) begin errors++; $display("FAIL short_blk_x got %0d want 5", blk_x); end
    checks++; if (err_short !== 1'b1) begin errors++; $display("FAIL short_err got %0b want 1", err_short); end
    tick();
  endtask

  task automatic test_reset_mid_block();
    reset_dut();
    out_ready = 1'b0;
    fill_tbl(0, 16'd5, 16'd5);
    for (int b = 0; b < 3; b++) send_block(tbl, 16, 1'b0);
    checks++; if (err_ovf !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got ovf=%0b valid=%0b want 1/1", err_ovf, out_valid); end
    for (int i = 0; i < 8; i++) begin
      compare = 1'b1; mv_vertical = 4'(i); sad_in = 16'd3;
      tick();
    end
    rst_n = 1'b0;
    #2;
    checks++; if ({out_valid, best_mv, best_sad, blk_x, blk_y} !== 39'd0) begin errors++; $display("FAIL mid_outputs got v=%0b mv=%0d sad=%0d (%0d,%0d) want all 0", out_valid, best_mv, best_sad, blk_x, blk_y); end
    checks++; if ({frame_done, err_short, err_ovf} !== 3'b000) begin errors++; $display("FAIL mid_flags got %b want 000", {frame_done, err_short, err_ovf}); end
    compare = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    fill_tbl(6, 16'd3, 16'd50);
    send_block(tbl, 16, 1'b1);
    checks++; if (blk_x !== 9'd0 || blk_y !== 9'd0) begin errors++; $display("FAIL mid_next_blk got (%0d,%0d) want (0,0)", blk_x, blk_y); end
    checks++; if (best_mv !== 4'd6 || best_sad !== 16'd3) begin errors++; $display("FAIL mid_next got mv=%0d sad=%0d want 6/3", best_mv, best_sad); end
    checks++; if (err_short !== 1'b0 || err_ovf !== 1'b0) begin errors++; $display("FAIL mid_next_err got short=%0b ovf=%0b want 0/0", err_short, err_ovf); end
    tick();
  endtask

  task automatic test_row_wrap();
    reset_dut();
    out_ready = 1'b1;
    for (int k = 0; k <= 480; k++) begin
      tbl[0] = 16'(k);
      send_block(tbl, 1, 1'b1);
      if (k == 479) begin
        checks++; if (blk_x !== 9'd479 || blk_y !== 9'd0) begin errors++; $display("FAIL row_end got (%0d,%0d) want (479,0)", blk_x, blk_y); end
      end
      if (k == 480) begin
        checks++; if (blk_x !== 9'd0 || blk_y !== 9'd1) begin errors++; $display("FAIL row_wrap got (%0d,%0d) want (0,1)", blk_x, blk_y); end
        checks++; if (best_sad !== 16'd480) begin errors++; $display("FAIL row_wrap_sad got %0d want 480", best_sad); end
      end
    end
    tick();
    checks++; if (fd_main !== 0) begin errors++; $display("FAIL row_no_frame_done got %0d pulses want 0", fd_main); end
  endtask

  task automatic test_frame_wrap();
    f_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      f_compare = 1'b1; f_mv = 4'(k); f_sad = 16'(k + 1);
      tick();
      f_compare = 1'b0;
      tick();
      checks++; if (f_frame_done !== 1'(k == 5)) begin errors++; $display("FAIL frame_pulse blk %0d got %0b want %0b", k, f_frame_done, (k == 5)); end
      if (k == 5) begin
        checks++; if (f_blk_x !== 9'd2 || f_blk_y !== 9'd1) begin errors++; $display("FAIL frame_last got (%0d,%0d) want (2,1)", f_blk_x, f_blk_y); end
      end
      if (k == 6) begin
        checks++; if (f_blk_x !== 9'd0 || f_blk_y !== 9'd0 || f_best_mv !== 4'd6) begin errors++; $display("FAIL frame_wrap got (%0d,%0d) mv=%0d want (0,0) mv=6", f_blk_x, f_blk_y, f_best_mv); end
      end
    end
    tick();
    tick();
    checks++; if (fd_small !== 1) begin errors++; $display("FAIL frame_pulse_count got %0d want 1", fd_small); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_overflow();
    test_short();
    test_reset_mid_block();
    test_row_wrap();
    test_frame_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
